// File: rtl/axi4_mem_pkg.sv
// Shared types and the beat-address helper for the AXI4 burst memory slave.
// Optional range/size/WLAST checking is enabled by defining AXI4_MEM_ERR_CHECK_EN.
package axi4_mem_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'd0,
    BURST_INCR  = 2'd1,
    BURST_WRAP  = 2'd2
  } burst_t;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } resp_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wstate_t;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_FETCH = 2'd1,
    R_DATA  = 2'd2
  } rstate_t;

  // WRAP bursts are only meaningful for 2, 4, 8 or 16 beats.
  function automatic logic wrap_len_ok(input logic [7:0] len);
    wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

  // Address of the beat following 'addr'. Carried at 64 bits so any
  // ADDR_WIDTH up to 64 can use it; callers truncate the result.
  function automatic logic [63:0] next_beat_addr(input logic [63:0] addr,
                                                 input logic [2:0]  size,
                                                 input logic [7:0]  len,
                                                 input burst_t      burst);
    logic [63:0] bytes_s;
    logic [63:0] incr_s;
    logic [63:0] mask_s;
    bytes_s = 64'd1 << size;
    incr_s  = addr + bytes_s;
    mask_s  = (bytes_s * ({56'd0, len} + 64'd1)) - 64'd1;
    case (burst)
      BURST_FIXED: next_beat_addr = addr;
      BURST_WRAP: begin
        if (wrap_len_ok(len)) begin
          next_beat_addr = (addr & ~mask_s) | (incr_s & mask_s);
        end else begin
          next_beat_addr = incr_s;
        end
      end
      default: next_beat_addr = incr_s;
    endcase
  endfunction

endpackage

// File: rtl/axi4_mem_array.sv
// Simple dual-port RAM: byte-enable write port, registered read port.
// Only the read register is reset; the storage itself is never cleared.
module axi4_mem_array #(
  parameter int DATA_WIDTH   = 32,
  parameter int MEMORY_DEPTH = 1024,
  parameter int IDX_W        = $clog2(MEMORY_DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [IDX_W-1:0]        wr_idx,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_strb,
  input  logic                    rd_en,
  input  logic                    rd_clr,
  input  logic [IDX_W-1:0]        rd_idx,
  output logic [DATA_WIDTH-1:0]   rd_data
);

  localparam int NB = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem_q [MEMORY_DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;

  // Byte-lane write into the storage array.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < NB; b++) begin
        if (wr_strb[b]) begin
          mem_q[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
        end
      end
    end
  end

  // Registered read; a same-cycle write to the same word is not visible (old data).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q <= '0;
    end else if (rd_en) begin
      rd_data_q <= rd_clr ? '0 : mem_q[rd_idx];
    end else begin
      rd_data_q <= rd_data_q;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/axi4_burst_mem_slave.sv
// AXI4 memory-mapped slave with independent write and read burst engines.
// Define AXI4_MEM_ERR_CHECK_EN to enable range/SIZE/WRAP/WLAST checking with SLVERR.
module axi4_burst_mem_slave
  import axi4_mem_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 16,
  parameter int MEMORY_DEPTH = 1024
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic [ADDR_WIDTH-1:0]   AWADDR,
  input  logic [7:0]              AWLEN,
  input  logic [2:0]              AWSIZE,
  input  logic [1:0]              AWBURST,
  input  logic                    AWVALID,
  output logic                    AWREADY,
  input  logic [DATA_WIDTH-1:0]   WDATA,
  input  logic [DATA_WIDTH/8-1:0] WSTRB,
  input  logic                    WLAST,
  input  logic                    WVALID,
  output logic                    WREADY,
  output logic [1:0]              BRESP,
  output logic                    BVALID,
  input  logic                    BREADY,
  input  logic [ADDR_WIDTH-1:0]   ARADDR,
  input  logic [7:0]              ARLEN,
  input  logic [2:0]              ARSIZE,
  input  logic [1:0]              ARBURST,
  input  logic                    ARVALID,
  output logic                    ARREADY,
  output logic [DATA_WIDTH-1:0]   RDATA,
  output logic [1:0]              RRESP,
  output logic                    RLAST,
  output logic                    RVALID,
  input  logic                    RREADY
);

  localparam int         NB       = DATA_WIDTH / 8;
  localparam int         IDX_W    = $clog2(MEMORY_DEPTH);
  localparam logic [2:0] BUS_SIZE = 3'($clog2(NB));
`ifdef AXI4_MEM_ERR_CHECK_EN
  localparam bit ERR_CHECK = 1'b1;
`else
  localparam bit ERR_CHECK = 1'b0;
`endif

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    in_range = (a >> BUS_SIZE) < ADDR_WIDTH'(MEMORY_DEPTH);
  endfunction

  // Unchecked builds fold any word index back into the array.
  function automatic logic [IDX_W-1:0] mem_idx(input logic [ADDR_WIDTH-1:0] a);
    mem_idx = IDX_W'((a >> BUS_SIZE) % ADDR_WIDTH'(MEMORY_DEPTH));
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] adv(input logic [ADDR_WIDTH-1:0] a,
                                                input logic [7:0] len, input burst_t b);
    adv = ADDR_WIDTH'(next_beat_addr(64'(a), BUS_SIZE, len, b));
  endfunction

  // ---------------- write engine ----------------
  wstate_t                 wstate_q, wstate_d;
  logic [ADDR_WIDTH-1:0]   waddr_q, waddr_d;
  logic [7:0]              wlen_q, wlen_d, wbeat_q, wbeat_d;
  burst_t                  wburst_q, wburst_d;
  logic                    werr_q, werr_d;
  logic                    awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic [1:0]              bresp_q, bresp_d;
  logic                    mem_we_s, w_in_range_s, w_last_beat_s, w_beat_err_s, aw_cfg_err_s;

  assign w_in_range_s  = in_range(waddr_q);
  assign w_last_beat_s = (wbeat_q == wlen_q);
  assign w_beat_err_s  = ERR_CHECK && (!w_in_range_s || (WLAST != w_last_beat_s));
  assign aw_cfg_err_s  = ERR_CHECK && ((AWSIZE != BUS_SIZE) ||
                         ((burst_t'(AWBURST) == BURST_WRAP) && !wrap_len_ok(AWLEN)));

  // Write FSM next state: AW latch, per-beat write/advance, sticky error, B hold.
  always_comb begin
    wstate_d = wstate_q;
    waddr_d  = waddr_q;
    wlen_d   = wlen_q;
    wburst_d = wburst_q;
    wbeat_d  = wbeat_q;
    werr_d   = werr_q;
    bresp_d  = bresp_q;
    mem_we_s = 1'b0;
    case (wstate_q)
      W_IDLE: begin
        bresp_d = RESP_OKAY;
        if (AWVALID && awready_q) begin
          waddr_d  = AWADDR;
          wlen_d   = AWLEN;
          wburst_d = burst_t'(AWBURST);
          wbeat_d  = 8'd0;
          werr_d   = aw_cfg_err_s;
          wstate_d = W_DATA;
        end else begin
          wstate_d = W_IDLE;
        end
      end
      W_DATA: begin
        if (WVALID && wready_q) begin
          mem_we_s = !ERR_CHECK || w_in_range_s;
          werr_d   = werr_q || w_beat_err_s;
          waddr_d  = adv(waddr_q, wlen_q, wburst_q);
          wbeat_d  = wbeat_q + 8'd1;
          if (w_last_beat_s) begin
            wstate_d = W_RESP;
            bresp_d  = werr_d ? RESP_SLVERR : RESP_OKAY;
          end else begin
            wstate_d = W_DATA;
          end
        end else begin
          wstate_d = W_DATA;
        end
      end
      W_RESP: begin
        if (BREADY && bvalid_q) begin
          wstate_d = W_IDLE;
        end else begin
          wstate_d = W_RESP;
        end
      end
      default: wstate_d = W_IDLE;
    endcase
    awready_d = (wstate_d == W_IDLE);
    wready_d  = (wstate_d == W_DATA);
    bvalid_d  = (wstate_d == W_RESP);
  end

  // Write engine registers; handshake outputs are decoded from the next state.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wstate_q  <= W_IDLE;
      waddr_q   <= '0;
      wlen_q    <= 8'd0;
      wburst_q  <= BURST_FIXED;
      wbeat_q   <= 8'd0;
      werr_q    <= 1'b0;
      bresp_q   <= 2'b00;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
    end else begin
      wstate_q  <= wstate_d;
      waddr_q   <= waddr_d;
      wlen_q    <= wlen_d;
      wburst_q  <= wburst_d;
      wbeat_q   <= wbeat_d;
      werr_q    <= werr_d;
      bresp_q   <= bresp_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
    end
  end

  // ---------------- read engine ----------------
  rstate_t                 rstate_q, rstate_d;
  logic [ADDR_WIDTH-1:0]   raddr_q, raddr_d;
  logic [7:0]              rlen_q, rlen_d, rbeat_q, rbeat_d;
  burst_t                  rburst_q, rburst_d;
  logic                    rerr_q, rerr_d;
  logic                    arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic [1:0]              rresp_q, rresp_d;
  logic                    mem_re_s, mem_rclr_s, r_in_range_s, ar_cfg_err_s;

  assign r_in_range_s = in_range(raddr_q);
  assign ar_cfg_err_s = ERR_CHECK && ((ARSIZE != BUS_SIZE) ||
                        ((burst_t'(ARBURST) == BURST_WRAP) && !wrap_len_ok(ARLEN)));

  // Read FSM next state: AR latch, one-cycle fetch, R hold until RREADY.
  always_comb begin
    rstate_d   = rstate_q;
    raddr_d    = raddr_q;
    rlen_d     = rlen_q;
    rburst_d   = rburst_q;
    rbeat_d    = rbeat_q;
    rerr_d     = rerr_q;
    rlast_d    = rlast_q;
    rresp_d    = rresp_q;
    mem_re_s   = 1'b0;
    mem_rclr_s = 1'b0;
    case (rstate_q)
      R_IDLE: begin
        rlast_d = 1'b0;
        rresp_d = RESP_OKAY;
        if (ARVALID && arready_q) begin
          raddr_d  = ARADDR;
          rlen_d   = ARLEN;
          rburst_d = burst_t'(ARBURST);
          rbeat_d  = 8'd0;
          rerr_d   = ar_cfg_err_s;
          rstate_d = R_FETCH;
        end else begin
          rstate_d = R_IDLE;
        end
      end
      R_FETCH: begin
        mem_re_s   = 1'b1;
        mem_rclr_s = ERR_CHECK && !r_in_range_s;
        rlast_d    = (rbeat_q == rlen_q);
        rresp_d    = (rerr_q || (ERR_CHECK && !r_in_range_s)) ? RESP_SLVERR : RESP_OKAY;
        rstate_d   = R_DATA;
      end
      R_DATA: begin
        if (RREADY && rvalid_q) begin
          if (rlast_q) begin
            rstate_d = R_IDLE;
          end else begin
            raddr_d  = adv(raddr_q, rlen_q, rburst_q);
            rbeat_d  = rbeat_q + 8'd1;
            rstate_d = R_FETCH;
          end
        end else begin
          rstate_d = R_DATA;
        end
      end
      default: rstate_d = R_IDLE;
    endcase
    arready_d = (rstate_d == R_IDLE);
    rvalid_d  = (rstate_d == R_DATA);
  end

  // Read engine registers.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      rstate_q  <= R_IDLE;
      raddr_q   <= '0;
      rlen_q    <= 8'd0;
      rburst_q  <= BURST_FIXED;
      rbeat_q   <= 8'd0;
      rerr_q    <= 1'b0;
      rlast_q   <= 1'b0;
      rresp_q   <= 2'b00;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
    end else begin
      rstate_q  <= rstate_d;
      raddr_q   <= raddr_d;
      rlen_q    <= rlen_d;
      rburst_q  <= rburst_d;
      rbeat_q   <= rbeat_d;
      rerr_q    <= rerr_d;
      rlast_q   <= rlast_d;
      rresp_q   <= rresp_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
    end
  end

  axi4_mem_array #(
    .DATA_WIDTH  (DATA_WIDTH),
    .MEMORY_DEPTH(MEMORY_DEPTH),
    .IDX_W       (IDX_W)
  ) u_array (
    .clk    (ACLK),
    .rst    (ARESET),
    .wr_en  (mem_we_s),
    .wr_idx (mem_idx(waddr_q)),
    .wr_data(WDATA),
    .wr_strb(WSTRB),
    .rd_en  (mem_re_s),
    .rd_clr (mem_rclr_s),
    .rd_idx (mem_idx(raddr_q)),
    .rd_data(RDATA)
  );

  assign AWREADY = awready_q;
  assign WREADY  = wready_q;
  assign BVALID  = bvalid_q;
  assign BRESP   = bresp_q;
  assign ARREADY = arready_q;
  assign RVALID  = rvalid_q;
  assign RLAST   = rlast_q;
  assign RRESP   = rresp_q;

endmodule
